// File: rtl/mem_access_unit_pkg.sv
// Shared configuration for the memory-access stage: widths, one-hot op encodings,
// FSM state codes and byte-lane helpers.
package mem_access_unit_pkg;

    localparam int XLEN           = 32;
    localparam int XREG_ADDRWIDTH = 5;

    localparam logic [4:0] NO_LOAD = 5'b00000;
    localparam logic [4:0] LOAD_B  = 5'b00001;
    localparam logic [4:0] LOAD_H  = 5'b00010;
    localparam logic [4:0] LOAD_W  = 5'b00100;
    localparam logic [4:0] LOAD_BU = 5'b01000;
    localparam logic [4:0] LOAD_HU = 5'b10000;

    localparam logic [2:0] NO_STORE = 3'b000;
    localparam logic [2:0] STORE_B  = 3'b001;
    localparam logic [2:0] STORE_H  = 3'b010;
    localparam logic [2:0] STORE_W  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic [3:0] lane_be(input logic [4:0] ld, input logic [2:0] st,
                                           input logic [1:0] off);
        logic [3:0] be;
        if ((ld == LOAD_B) || (ld == LOAD_BU) || (st == STORE_B)) begin
            be = 4'b0001 << off;
        end else if ((ld == LOAD_H) || (ld == LOAD_HU) || (st == STORE_H)) begin
            be = 4'b0011 << off;
        end else begin
            be = 4'b1111;
        end
        return be;
    endfunction

    function automatic logic [XLEN-1:0] lane_wdata(input logic [2:0] st, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] w;
        case (st)
            STORE_B: w = {4{d[7:0]}};
            STORE_H: w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align_ext.sv
// Aligns a read word to the addressed byte/half and sign- or zero-extends it.
module load_align_ext
    import mem_access_unit_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [4:0]      load_flag,
    output logic [XLEN-1:0] ext_data
);

    logic [XLEN-1:0] field_s;

    // Shift the addressed lane down to bit 0 and extend by load type
    always_comb begin
        field_s = rdata >> {offset, 3'b000};
        case (load_flag)
            LOAD_B:  ext_data = {{24{field_s[7]}}, field_s[7:0]};
            LOAD_BU: ext_data = {24'h000000, field_s[7:0]};
            LOAD_H:  ext_data = {{16{field_s[15]}}, field_s[15:0]};
            LOAD_HU: ext_data = {16'h0000, field_s[15:0]};
            LOAD_W:  ext_data = rdata;
            default: ext_data = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: issues aligned byte-lane bus accesses for loads/stores and
// produces one registered writeback record per accepted EXU operation.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ex_valid_in,
    output logic                      ex_ready_out,
    input  logic [XLEN-1:0]           addr_in,
    input  logic [4:0]                load_flag_in,
    input  logic [2:0]                store_flag_in,
    input  logic [XLEN-1:0]           store_data_in,
    input  logic                      rd_en_in,
    input  logic [XREG_ADDRWIDTH-1:0] rd_addr_in,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [XLEN-1:0]           dmem_addr,
    output logic [3:0]                dmem_be,
    output logic [XLEN-1:0]           dmem_wdata,
    input  logic                      dmem_gnt,
    input  logic                      dmem_rvalid,
    input  logic [XLEN-1:0]           dmem_rdata,
    output logic                      wb_valid_out,
    output logic                      wb_rd_en_out,
    output logic [XREG_ADDRWIDTH-1:0] wb_rd_addr_out,
    output logic [XLEN-1:0]           wb_rd_data_out,
    output logic                      misalign_exc_out,
    output logic [XLEN-1:0]           misalign_addr_out
);

    state_e                    state_r, state_nx;
    logic                      req_r, req_nx, we_r, we_nx;
    logic [XLEN-1:0]           maddr_r, maddr_nx, wdata_r, wdata_nx;
    logic [3:0]                be_r, be_nx;
    logic [4:0]                ld_r, ld_nx;
    logic [1:0]                off_r, off_nx;
    logic                      rd_en_r, rd_en_nx;
    logic [XREG_ADDRWIDTH-1:0] rd_addr_r, rd_addr_nx;
    logic                      wb_valid_r, wb_valid_nx, wb_rd_en_r, wb_rd_en_nx;
    logic [XREG_ADDRWIDTH-1:0] wb_rd_addr_r, wb_rd_addr_nx;
    logic [XLEN-1:0]           wb_rd_data_r, wb_rd_data_nx;
    logic                      mis_exc_r, mis_exc_nx;
    logic [XLEN-1:0]           mis_addr_r, mis_addr_nx;

    logic                      accept_s, is_mem_s, half_s, word_s, mis_s, rd_wr_s;
    logic [2:0]                st_s;
    logic [XLEN-1:0]           ext_s;

    load_align_ext u_load_align_ext (
        .rdata     (dmem_rdata),
        .offset    (off_r),
        .load_flag (ld_r),
        .ext_data  (ext_s)
    );

    // Decode the incoming record; a load flag overrides any store flag
    always_comb begin
        accept_s = ex_valid_in && (state_r == ST_IDLE);
        st_s     = (load_flag_in != NO_LOAD) ? NO_STORE : store_flag_in;
        is_mem_s = (load_flag_in != NO_LOAD) || (st_s != NO_STORE);
        half_s   = (load_flag_in == LOAD_H) || (load_flag_in == LOAD_HU) || (st_s == STORE_H);
        word_s   = (load_flag_in == LOAD_W) || (st_s == STORE_W);
        mis_s    = (half_s && addr_in[0]) || (word_s && (addr_in[1:0] != 2'b00));
        rd_wr_s  = rd_en_in && (rd_addr_in != {XREG_ADDRWIDTH{1'b0}});
    end

    // Next-state and next-output logic; pulses default low, everything else holds
    always_comb begin
        state_nx      = state_r;
        req_nx        = req_r;
        we_nx         = we_r;
        maddr_nx      = maddr_r;
        be_nx         = be_r;
        wdata_nx      = wdata_r;
        ld_nx         = ld_r;
        off_nx        = off_r;
        rd_en_nx      = rd_en_r;
        rd_addr_nx    = rd_addr_r;
        wb_valid_nx   = 1'b0;
        wb_rd_en_nx   = wb_rd_en_r;
        wb_rd_addr_nx = wb_rd_addr_r;
        wb_rd_data_nx = wb_rd_data_r;
        mis_exc_nx    = 1'b0;
        mis_addr_nx   = mis_addr_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && mis_s) begin
                    wb_valid_nx   = 1'b1;
                    wb_rd_en_nx   = 1'b0;
                    wb_rd_addr_nx = rd_addr_in;
                    mis_exc_nx    = 1'b1;
                    mis_addr_nx   = addr_in;
                end else if (accept_s && is_mem_s) begin
                    state_nx   = ST_REQ;
                    req_nx     = 1'b1;
                    we_nx      = (st_s != NO_STORE);
                    maddr_nx   = {addr_in[XLEN-1:2], 2'b00};
                    be_nx      = lane_be(load_flag_in, st_s, addr_in[1:0]);
                    wdata_nx   = lane_wdata(st_s, store_data_in);
                    ld_nx      = load_flag_in;
                    off_nx     = addr_in[1:0];
                    rd_en_nx   = rd_wr_s && (load_flag_in != NO_LOAD);
                    rd_addr_nx = rd_addr_in;
                end else if (accept_s) begin
                    wb_valid_nx   = 1'b1;
                    wb_rd_en_nx   = rd_wr_s;
                    wb_rd_addr_nx = rd_addr_in;
                    wb_rd_data_nx = addr_in;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dmem_gnt && we_r) begin
                    state_nx      = ST_IDLE;
                    req_nx        = 1'b0;
                    wb_valid_nx   = 1'b1;
                    wb_rd_en_nx   = 1'b0;
                    wb_rd_addr_nx = rd_addr_r;
                end else if (dmem_gnt) begin
                    state_nx = ST_RESP;
                    req_nx   = 1'b0;
                end else begin
                    req_nx = 1'b1;
                end
            end
            ST_RESP: begin
                if (dmem_rvalid) begin
                    state_nx      = ST_IDLE;
                    wb_valid_nx   = 1'b1;
                    wb_rd_en_nx   = rd_en_r;
                    wb_rd_addr_nx = rd_addr_r;
                    wb_rd_data_nx = ext_s;
                end else begin
                    state_nx = ST_RESP;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                req_nx   = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            req_r        <= 1'b0;
            we_r         <= 1'b0;
            maddr_r      <= {XLEN{1'b0}};
            be_r         <= 4'b0000;
            wdata_r      <= {XLEN{1'b0}};
            ld_r         <= NO_LOAD;
            off_r        <= 2'b00;
            rd_en_r      <= 1'b0;
            rd_addr_r    <= {XREG_ADDRWIDTH{1'b0}};
            wb_valid_r   <= 1'b0;
            wb_rd_en_r   <= 1'b0;
            wb_rd_addr_r <= {XREG_ADDRWIDTH{1'b0}};
            wb_rd_data_r <= {XLEN{1'b0}};
            mis_exc_r    <= 1'b0;
            mis_addr_r   <= {XLEN{1'b0}};
        end else begin
            state_r      <= state_nx;
            req_r        <= req_nx;
            we_r         <= we_nx;
            maddr_r      <= maddr_nx;
            be_r         <= be_nx;
            wdata_r      <= wdata_nx;
            ld_r         <= ld_nx;
            off_r        <= off_nx;
            rd_en_r      <= rd_en_nx;
            rd_addr_r    <= rd_addr_nx;
            wb_valid_r   <= wb_valid_nx;
            wb_rd_en_r   <= wb_rd_en_nx;
            wb_rd_addr_r <= wb_rd_addr_nx;
            wb_rd_data_r <= wb_rd_data_nx;
            mis_exc_r    <= mis_exc_nx;
            mis_addr_r   <= mis_addr_nx;
        end
    end

    assign ex_ready_out      = (state_r == ST_IDLE);
    assign dmem_req          = req_r;
    assign dmem_we           = we_r;
    assign dmem_addr         = maddr_r;
    assign dmem_be           = be_r;
    assign dmem_wdata        = wdata_r;
    assign wb_valid_out      = wb_valid_r;
    assign wb_rd_en_out      = wb_rd_en_r;
    assign wb_rd_addr_out    = wb_rd_addr_r;
    assign wb_rd_data_out    = wb_rd_data_r;
    assign misalign_exc_out  = mis_exc_r;
    assign misalign_addr_out = mis_addr_r;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage block between the execute-stage ALU and writeback.
- Takes the EXU result: effective address or ALU result, load/store type flags, store data, rd address and enable.
- Performs aligned byte-lane accesses to data memory over a req/gnt/rvalid bus, then sign- or zero-extends load data.
- Presents one registered writeback record per accepted operation and stalls upstream while a memory transaction is outstanding.

Parameters:
XLEN, 32, data/address width
XREG_ADDRWIDTH, 5, register index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ex_valid_in  in  1  EXU record valid
ex_ready_out  out  1  unit can accept a record this cycle
addr_in  in  XLEN  effective address (mem ops) or ALU result (others)
load_flag_in  in  5  load type, one-hot: LOAD_B=00001, LOAD_H=00010, LOAD_W=00100, LOAD_BU=01000, LOAD_HU=10000, NO_LOAD=0
store_flag_in  in  3  store type, one-hot: STORE_B=001, STORE_H=010, STORE_W=100, NO_STORE=0
store_data_in  in  XLEN  rs2 value for stores
rd_en_in  in  1  writeback enable
rd_addr_in  in  XREG_ADDRWIDTH  destination register
dmem_req  out  1  bus request
dmem_we  out  1  1=write
dmem_addr  out  XLEN  word address, bits[1:0]=0
dmem_be  out  4  byte enables
dmem_wdata  out  XLEN  lane-replicated store data
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  read data valid
dmem_rdata  in  XLEN  read data word
wb_valid_out  out  1  one-cycle writeback pulse
wb_rd_en_out  out  1  write rd
wb_rd_addr_out  out  XREG_ADDRWIDTH  rd index
wb_rd_data_out  out  XLEN  result
misalign_exc_out  out  1  one-cycle misaligned-access pulse
misalign_addr_out  out  XLEN  faulting address, held until next fault

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except ex_ready_out=1. Any outstanding bus response is dropped; the bus shares rst_n.
- FSM states IDLE, REQ, RESP. ex_ready_out = (state==IDLE). A record is accepted when ex_valid_in && ex_ready_out; all inputs are captured.
- Load flag nonzero takes priority if both load and store flags are nonzero; the store is ignored.
- Non-memory op: stays IDLE. Next cycle: wb_valid_out=1, wb_rd_data_out=addr_in. Latency 1; back-to-back acceptance allowed.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]!=0.
  - No bus request is made; stays IDLE.
  - Next cycle: misalign_exc_out=1, misalign_addr_out=addr, wb_valid_out=1, wb_rd_en_out=0.
- Aligned load/store: IDLE→REQ. In REQ, dmem_req=1 and address, we, be and wdata are held stable until dmem_gnt.
  - Store: on gnt → IDLE. Next cycle: wb_valid_out=1, wb_rd_en_out=0.
  - Load: on gnt → RESP, dmem_req=0.
- In RESP, on dmem_rvalid → IDLE. Next cycle: wb_valid_out=1, wb_rd_data_out=extended data.
- Bus guarantees rvalid no earlier than the cycle after gnt; rvalid outside RESP is ignored.
- Minimum load: accept N, req/gnt N+1, rvalid N+2, wb N+3. Minimum store: wb N+2.
- Byte lanes, with o=addr[1:0]:
  - SB: be=0001<<o, wdata={4{d[7:0]}}.
  - SH: be=0011<<o, wdata={2{d[15:0]}}.
  - SW: be=1111, wdata=d.
- Load extraction: field = rdata>>(8*o), then extend:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word.
- wb_rd_en_out = captured rd_en && rd_addr!=0, except forced 0 for stores and faults.
- wb_valid_out and misalign_exc_out are 1-cycle pulses; the other wb_* outputs hold their last value.

Decomposition:
- Shared config header: XLEN, XREG_ADDRWIDTH, LOAD_*/STORE_* encodings, FSM state codes.
- Combinational sub-module load_align_ext, (rdata, offset, load_flag) → extended data, reused by a future cache path.

Test Plan:
- Non-mem: addr_in=0x1234, rd=5, rd_en=1 → next cycle wb_valid=1, data 0x1234, rd_en=1; second record the following cycle also accepted.
- SB at 0x103, data 0xAABBCCDD, gnt after 2 wait cycles → dmem_addr=0x100, be=1000, wdata=0xDDDDDDDD held through the waits; wb pulse with rd_en=0.
- LB at 0x102, rdata=0x00800000 → wb data 0xFFFFFF80; LBU same → 0x00000080; LHU at 0x102 of 0x8001xxxx → 0x00008001.
- LW at 0x006 → no dmem_req; misalign_exc=1, misalign_addr=0x006, wb_rd_en=0.
- Load to rd=0 with rd_en=1 → wb_valid=1, wb_rd_en=0.
- Reset asserted in RESP → outputs 0 immediately, ex_ready=1; a later stray rvalid produces no wb pulse.
